// File: rtl/byte_accumulator_pkg.sv
// Shared types and widths for the byte accumulator slice.
package byte_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SUM_W  = 16;
    localparam int unsigned CNT_W  = 4;

endpackage

// File: rtl/byte_accumulator_fulladder8.sv
// 8-bit ripple full adder with carry in/out; chained to build the 16-bit sum.
module fulladder8
    import byte_accumulator_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              c_i,
    output logic [BYTE_W-1:0] s_o,
    output logic              c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{BYTE_W{1'b0}}, c_i};

endmodule

// File: rtl/byte_accumulator.sv
// Sums N_SAMPLES unsigned bytes per frame and holds the result until consumed.
// Define BYTE_ACCUMULATOR_SAT_EN to clamp the sum at 16'hFFFF instead of wrapping.
module byte_accumulator
    import byte_accumulator_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [SUM_W-1:0]  out_sum,
    output logic              out_ovf,
    input  logic              out_ready
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    state_e            state_q, state_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [BYTE_W-1:0] sum_lo, sum_hi;
    logic              carry_lo, carry_hi;
    logic [SUM_W-1:0]  acc_next;
    logic              accept;

    fulladder8 u_add_lo (
        .a_i (acc_q[BYTE_W-1:0]),
        .b_i (in_data),
        .c_i (1'b0),
        .s_o (sum_lo),
        .c_o (carry_lo)
    );

    fulladder8 u_add_hi (
        .a_i (acc_q[SUM_W-1:BYTE_W]),
        .b_i ({BYTE_W{1'b0}}),
        .c_i (carry_lo),
        .s_o (sum_hi),
        .c_o (carry_hi)
    );

`ifdef BYTE_ACCUMULATOR_SAT_EN
    // Once saturated, stay pinned at full scale for the rest of the frame.
    assign acc_next = (carry_hi || ovf_q) ? '1 : {sum_hi, sum_lo};
`else
    assign acc_next = {sum_hi, sum_lo};
`endif

    // Ready depends only on state and reset, never on in_valid.
    assign in_ready  = rst_n && (state_q == ACCUM);
    assign accept    = in_valid && in_ready && !clr;
    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = acc_next;
                        ovf_d = ovf_q | carry_hi;
                        if (cnt_q == LAST_CNT) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: doc/byte_accumulator.md
BYTE_ACCUMULATOR -- requirements
Module: byte_accumulator

Interface
REQ-001 Parameter N_SAMPLES, default 4, bytes summed per frame; the legal range SHALL be 1..15.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 clr  input  1  synchronous frame flush, active-high.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_data  input  8  unsigned byte to accumulate.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_valid  output  1  out_sum and out_ovf hold a completed frame result.
REQ-009 out_sum  output  16  unsigned frame sum.
REQ-010 out_ovf  output  1  the frame sum exceeded 16'hFFFF.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.

Function
REQ-012 The block SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-013 A byte SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; no combinational path SHALL exist from in_valid to in_ready.
REQ-014 Each accepted byte SHALL be added as acc_next = acc + zero_extend(in_data), using an 8-bit low-byte add plus a carry into a high-byte add.
REQ-015 A 4-bit counter SHALL count accepted bytes in the frame; it SHALL clear on frame completion, clr, and reset.
REQ-016 On acceptance of byte N_SAMPLES, the FSM SHALL go to HOLD in the next cycle with out_sum=acc_next, i.e. one-cycle latency from the last accepted byte to out_valid.
REQ-017 In HOLD, out_sum and out_ovf SHALL remain stable until out_ready=1 is sampled.
REQ-018 On out_ready=1 in HOLD, the FSM SHALL return to ACCUM next cycle with acc=0 and out_valid=0; the first byte of the next frame SHALL be accepted no earlier than that cycle.
REQ-019 out_ready while in ACCUM SHALL be ignored.
REQ-020 out_ovf SHALL be sticky within a frame: it is set by any carry out of bit 15 and cleared only at frame start, on clr, or on reset.
REQ-021 Without saturation (see REQ-026), the sum SHALL wrap modulo 2^16.
REQ-022 clr=1 SHALL, in the next cycle, force ACCUM with acc, counter and out_ovf cleared; any in-flight or held result SHALL be discarded, and a byte presented on the same cycle SHALL NOT be accepted.
REQ-023 With N_SAMPLES=1, every accepted byte SHALL produce its own frame (out_sum = {8'h00, in_data}).

Reset
REQ-024 While rst_n=0 at a rising edge, the block SHALL enter ACCUM with acc=0, counter=0, out_sum=16'h0000, out_ovf=0, out_valid=0, and in_ready=0 during the reset cycle.
REQ-025 rst_n SHALL take priority over clr; reset mid-frame or in HOLD SHALL discard all partial and held state.

Configuration
REQ-026 Macro BYTE_ACCUMULATOR_SAT_EN: when defined, a carry out of bit 15 SHALL clamp acc to 16'hFFFF and keep it there for the rest of the frame, with out_ovf still set; when undefined, the wrap rule of REQ-021 applies.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (ACCUM, HOLD), the byte width 8, the sum width 16, and the counter width 4.
REQ-028 The datapath SHALL instantiate the team's existing 8-bit full-adder block (fulladder8) twice, low byte then high byte with carry-chained; no other sub-module.

Verification
REQ-029 N=4; bytes 08,02,0C,F2 with in_valid continuous and out_ready=1 -> out_valid one cycle after the 4th byte, out_sum=0x0108, out_ovf=0, in_ready=0 in HOLD.
REQ-030 Backpressure: frame as above with out_ready=0 for 5 cycles -> out_sum stays 0x0108 for all 5 cycles, in_ready=0, and the next byte is accepted only after the out_ready handshake.
REQ-031 N=15 with all bytes FF (sum 0x0EF1) -> out_ovf=0; then a preloaded acc near the wrap point, adding 0xFF past 0xFFFF -> out_ovf=1, out_sum wraps (or reads 0xFFFF with BYTE_ACCUMULATOR_SAT_EN defined).
REQ-032 clr asserted after 2 of 4 bytes (07,09), then bytes 05,07,01,02 -> out_sum=0x000F, with no contribution from the discarded bytes.
REQ-033 rst_n=0 for 1 cycle while in HOLD -> next cycle out_valid=0, out_sum=0, in_ready=1 after rst_n returns high.
REQ-034 N=1; bytes 00 then FF in consecutive accept windows -> two frames with out_sum=0x0000 and 0x00FF.
